// File: rtl/seg_scan_if.sv
// Signal bundle between a multiplexed 4-digit seven-segment driver and the scan decoder.
// The master drives the display lines; the slave decodes them.
interface seg_scan_if;
  logic [0:6] sevenSegmentsa2g;
  logic [3:0] anodeDrives;
  logic       dp;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic [3:0] dp_mask;
  logic       frame_valid;
  logic       frame_strobe;
  logic       err_seg;
  logic       err_anode;

  modport master (
    output sevenSegmentsa2g, anodeDrives, dp,
    input  digit3, digit2, digit1, digit0, dp_mask,
    input  frame_valid, frame_strobe, err_seg, err_anode
  );

  modport slave (
    input  sevenSegmentsa2g, anodeDrives, dp,
    output digit3, digit2, digit1, digit0, dp_mask,
    output frame_valid, frame_strobe, err_seg, err_anode
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers hex digits and decimal points from a multiplexed, active-low 4-digit
// seven-segment scan, with stability filtering, frame tracking and staleness timeout.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input logic       clk,
  input logic       reset,
  seg_scan_if.slave bus
);
  localparam int unsigned RUN_W = 8;
  localparam int unsigned TMO_W = 24;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ACC = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_HIT = TMO_W'(TIMEOUT_CYCLES - 1);

  // Returns {valid, value} for an active-high abcdefg pattern.
  function automatic logic [4:0] decode_seg(input logic [0:6] pat);
    case (pat)
      7'b1111110: decode_seg = {1'b1, 4'h0};
      7'b0110000: decode_seg = {1'b1, 4'h1};
      7'b1101101: decode_seg = {1'b1, 4'h2};
      7'b1111001: decode_seg = {1'b1, 4'h3};
      7'b0110011: decode_seg = {1'b1, 4'h4};
      7'b1011011: decode_seg = {1'b1, 4'h5};
      7'b1011111: decode_seg = {1'b1, 4'h6};
      7'b1110000: decode_seg = {1'b1, 4'h7};
      7'b1111111: decode_seg = {1'b1, 4'h8};
      7'b1111011: decode_seg = {1'b1, 4'h9};
      7'b1110111: decode_seg = {1'b1, 4'hA};
      7'b0011111: decode_seg = {1'b1, 4'hB};
      7'b1001110: decode_seg = {1'b1, 4'hC};
      7'b0111101: decode_seg = {1'b1, 4'hD};
      7'b1001111: decode_seg = {1'b1, 4'hE};
      7'b1000111: decode_seg = {1'b1, 4'hF};
      default:    decode_seg = {1'b0, 4'h0};
    endcase
  endfunction

  // Vector layout: {anodes[3:0], segments a..g, dp}, all still active-low.
  logic [11:0]       sync1_q, sync2_q, prev_q;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [3:0][3:0]   digit_q, digit_d;
  logic [3:0]        dp_mask_q, dp_mask_d;
  logic [3:0]        seen_q, seen_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_strobe_q, frame_strobe_d;
  logic              err_seg_q, err_seg_d;
  logic              err_anode_q, err_anode_d;

  logic [3:0] anode_act_s;
  logic [0:6] pat_s;
  logic       dp_lit_s, seg_ok_s, same_s, accept_s, one_hot_s, multi_s, write_s, timeout_s;
  logic [3:0] seg_val_s;

  // Acceptance, decode and next-state logic.
  always_comb begin
    anode_act_s = ~sync2_q[11:8];
    pat_s       = ~sync2_q[7:1];
    dp_lit_s    = ~sync2_q[0];
    {seg_ok_s, seg_val_s} = decode_seg(pat_s);
    same_s    = (sync2_q == prev_q);
    accept_s  = same_s && (run_q == RUN_ACC);
    one_hot_s = (anode_act_s != 4'b0000) &&
                ((anode_act_s & (anode_act_s - 4'b0001)) == 4'b0000);
    multi_s   = (anode_act_s != 4'b0000) && !one_hot_s;
    write_s   = accept_s && one_hot_s && seg_ok_s;
    timeout_s = !write_s && (tmo_q == TMO_HIT);

    run_d          = run_q;
    tmo_d          = tmo_q;
    digit_d        = digit_q;
    dp_mask_d      = dp_mask_q;
    seen_d         = seen_q;
    frame_valid_d  = frame_valid_q;
    frame_strobe_d = 1'b0;

    if (!same_s) begin
      run_d = {RUN_W{1'b0}};
    end else if (run_q == RUN_MAX) begin
      run_d = run_q;
    end else begin
      run_d = run_q + 8'd1;
    end

    if (write_s) begin
      tmo_d = {TMO_W{1'b0}};
    end else if (tmo_q == TMO_MAX) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 24'd1;
    end

    if (timeout_s) begin
      frame_valid_d = 1'b0;
      seen_d        = 4'b0000;
    end else begin
      frame_valid_d = frame_valid_q;
      seen_d        = seen_q;
    end

    // Completion is taken one edge after the write that filled the last position.
    if (seen_q == 4'b1111) begin
      frame_strobe_d = 1'b1;
      frame_valid_d  = 1'b1;
      seen_d         = 4'b0000;
    end else begin
      frame_strobe_d = 1'b0;
    end

    if (write_s) begin
      for (int k = 0; k < 4; k++) begin
        digit_d[k]   = anode_act_s[k] ? seg_val_s : digit_q[k];
        dp_mask_d[k] = anode_act_s[k] ? dp_lit_s  : dp_mask_q[k];
      end
      seen_d = seen_d | anode_act_s;
    end else begin
      digit_d   = digit_q;
      dp_mask_d = dp_mask_q;
    end

    err_anode_d = accept_s && multi_s;
    err_seg_d   = accept_s && one_hot_s && !seg_ok_s;
  end

  // State registers; synchronizer resets to the all-ones (dark display) vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q        <= 12'hFFF;
      sync2_q        <= 12'hFFF;
      prev_q         <= 12'hFFF;
      run_q          <= {RUN_W{1'b0}};
      tmo_q          <= {TMO_W{1'b0}};
      digit_q        <= 16'h0000;
      dp_mask_q      <= 4'b0000;
      seen_q         <= 4'b0000;
      frame_valid_q  <= 1'b0;
      frame_strobe_q <= 1'b0;
      err_seg_q      <= 1'b0;
      err_anode_q    <= 1'b0;
    end else begin
      sync1_q        <= {bus.anodeDrives, bus.sevenSegmentsa2g, bus.dp};
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      run_q          <= run_d;
      tmo_q          <= tmo_d;
      digit_q        <= digit_d;
      dp_mask_q      <= dp_mask_d;
      seen_q         <= seen_d;
      frame_valid_q  <= frame_valid_d;
      frame_strobe_q <= frame_strobe_d;
      err_seg_q      <= err_seg_d;
      err_anode_q    <= err_anode_d;
    end
  end

  assign bus.digit0       = digit_q[0];
  assign bus.digit1       = digit_q[1];
  assign bus.digit2       = digit_q[2];
  assign bus.digit3       = digit_q[3];
  assign bus.dp_mask      = dp_mask_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.frame_strobe = frame_strobe_q;
  assign bus.err_seg      = err_seg_q;
  assign bus.err_anode    = err_anode_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed-vector bench for seg_scan_decoder: a raw-input-history model checked every
// cycle, plus hand-computed literal expectations after each scenario.
module tb_seg_scan_decoder;
  localparam int S = 4;
  localparam int T = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  seg_scan_if bus();

  seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [0:6] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int n_vec = 0;
  int n_fail = 0;
  int strobe_cnt = 0, eseg_cnt = 0, eanode_cnt = 0;

  // Model state: outputs derived from how long the raw input has been held.
  logic [3:0]  m_digit [4];
  logic [3:0]  m_dpm, m_seen;
  logic        m_valid, m_strobe, m_eseg, m_eanode;
  int          m_tmo, hold;
  logic [11:0] last_r;
  bit          have_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
    m_dpm = 4'b0000; m_seen = 4'b0000;
    m_valid = 1'b0; m_strobe = 1'b0; m_eseg = 1'b0; m_eanode = 1'b0;
    m_tmo = 0; hold = 0; have_last = 1'b0; last_r = 12'h000;
  endtask

  task automatic model_step();
    logic [11:0] r;
    logic [3:0]  act, nseen;
    logic [0:6]  pat;
    logic        nvalid;
    int n, k, val;
    bit ok, acc, wr;
    r = {bus.anodeDrives, bus.sevenSegmentsa2g, bus.dp};
    if (have_last && r == last_r) begin
      if (hold < 1000) hold++;
    end else begin
      hold = 1;
    end
    last_r = r; have_last = 1'b1;
    act = ~bus.anodeDrives;
    pat = ~bus.sevenSegmentsa2g;
    n = $countones(act);
    k = 0;
    for (int i = 0; i < 4; i++) if (act[i]) k = i;
    ok = 1'b0; val = 0;
    for (int h = 0; h < 16; h++) if (tbl[h] == pat) begin ok = 1'b1; val = h; end
    // Inputs stable from edge t take effect at edge t+S+2, i.e. the (S+3)-th equal sample.
    acc = (hold == S + 3);
    wr  = acc && (n == 1) && ok;
    nseen = m_seen; nvalid = m_valid;
    if (!wr && m_tmo == T - 1) begin nvalid = 1'b0; nseen = 4'b0000; end
    m_strobe = (m_seen == 4'b1111);
    if (m_strobe) begin nvalid = 1'b1; nseen = 4'b0000; end
    m_eanode = acc && (n > 1);
    m_eseg   = acc && (n == 1) && !ok;
    if (wr) begin
      m_digit[k] = val[3:0];
      m_dpm[k]   = ~bus.dp;
      nseen[k]   = 1'b1;
      m_tmo      = 0;
    end else if (m_tmo < T) begin
      m_tmo++;
    end
    m_seen = nseen; m_valid = nvalid;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("digit0", bus.digit0, m_digit[0]);
      check("digit1", bus.digit1, m_digit[1]);
      check("digit2", bus.digit2, m_digit[2]);
      check("digit3", bus.digit3, m_digit[3]);
      check("dp_mask", bus.dp_mask, m_dpm);
      check("frame_valid", bus.frame_valid, m_valid);
      check("frame_strobe", bus.frame_strobe, m_strobe);
      check("err_seg", bus.err_seg, m_eseg);
      check("err_anode", bus.err_anode, m_eanode);
      check("err_exclusive", bus.err_seg & bus.err_anode, 1'b0);
      if (bus.frame_strobe === 1'b1) strobe_cnt++;
      if (bus.err_seg === 1'b1) eseg_cnt++;
      if (bus.err_anode === 1'b1) eanode_cnt++;
    end
  end

  task automatic show_raw(input logic [3:0] an, input logic [0:6] seg, input logic d, input int n);
    bus.anodeDrives = an; bus.sevenSegmentsa2g = seg; bus.dp = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input logic [3:0] an, input int h, input bit dp_on, input int n);
    show_raw(an, ~tbl[h], ~dp_on, n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h0000);
    check({tag, "_dp_mask"}, bus.dp_mask, 4'b0000);
    check({tag, "_flags"}, {bus.frame_valid, bus.frame_strobe, bus.err_seg, bus.err_anode}, 4'b0000);
    check({tag, "_seen"}, dut.seen_q, 4'b0000);
  endtask

  task automatic check_digits(input string tag, input logic [15:0] exp);
    check(tag, {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, exp);
  endtask

  initial begin
    bus.anodeDrives = 4'b1111; bus.sevenSegmentsa2g = 7'b1111111; bus.dp = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    show_raw(4'b1111, 7'b1111111, 1'b1, 20);

    // First frame 1,5,0,3 with dp on digit 1; pins the S+2 write latency.
    strobe_cnt = 0;
    show(4'b1110, 3, 1'b0, 6);
    check("latency_before", bus.digit0, 4'h0);
    show(4'b1110, 3, 1'b0, 1);
    check("latency_at", bus.digit0, 4'h3);
    show(4'b1110, 3, 1'b0, 3);
    show(4'b1101, 0, 1'b1, 10);
    show(4'b1011, 5, 1'b0, 10);
    show(4'b0111, 1, 1'b0, 10);
    check_digits("frame1_digits", 16'h1503);
    check("frame1_dp_mask", bus.dp_mask, 4'b0010);
    check("frame1_valid", bus.frame_valid, 1'b1);
    check("frame1_strobes", strobe_cnt, 1);

    // Timeout: last write was 4 edges ago, so valid drops 12 edges later.
    show_raw(4'b1111, 7'b1111111, 1'b1, 12);
    check("tmo_still_valid", bus.frame_valid, 1'b1);
    show_raw(4'b1111, 7'b1111111, 1'b1, 1);
    check("tmo_dropped", bus.frame_valid, 1'b0);
    check_digits("tmo_retained", 16'h1503);
    check("tmo_dp_retained", bus.dp_mask, 4'b0010);
    show_raw(4'b1111, 7'b1111111, 1'b1, 10);

    // Pattern toggling faster than the filter accepts.
    eseg_cnt = 0; eanode_cnt = 0;
    for (int i = 0; i < 10; i++) show(4'b1110, (i % 2 == 0) ? 8 : 0, 1'b0, 2);
    show_raw(4'b1111, 7'b1111111, 1'b1, 10);
    check("toggle_digit0", bus.digit0, 4'h3);
    check("toggle_errs", eseg_cnt + eanode_cnt, 0);

    // Two anodes active at once.
    eanode_cnt = 0;
    show(4'b1100, 8, 1'b0, 10);
    show_raw(4'b1111, 7'b1111111, 1'b1, 10);
    check("multi_anode_pulses", eanode_cnt, 1);
    check_digits("multi_anode_digits", 16'h1503);

    // Only segment g lit: not a hex glyph.
    eseg_cnt = 0;
    show_raw(4'b1011, 7'b1111110, 1'b1, 10);
    check("bad_seg_pulses", eseg_cnt, 1);
    check("bad_seg_seen2", dut.seen_q[2], 1'b0);
    check("bad_seg_digit2", bus.digit2, 4'h5);
    show_raw(4'b1111, 7'b1111111, 1'b1, 10);

    // Second frame d,C,b,A with dp on digit 0.
    strobe_cnt = 0;
    show(4'b1110, 10, 1'b1, 10);
    show(4'b1101, 11, 1'b0, 10);
    show(4'b1011, 12, 1'b0, 10);
    show(4'b0111, 13, 1'b0, 10);
    check_digits("frame2_digits", 16'hDCBA);
    check("frame2_dp_mask", bus.dp_mask, 4'b0001);
    check("frame2_strobes", strobe_cnt, 1);

    // Reset mid-frame after three writes, then a full fresh scan.
    show(4'b1110, 7, 1'b1, 10);
    show(4'b1101, 8, 1'b0, 10);
    show(4'b1011, 9, 1'b0, 10);
    check_digits("pre_reset_digits", 16'hD987);
    check("pre_reset_valid", bus.frame_valid, 1'b1);
    show(4'b0111, 1, 1'b0, 3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    strobe_cnt = 0;
    show(4'b0111, 1, 1'b0, 10);
    show(4'b1110, 4, 1'b0, 10);
    show(4'b1101, 2, 1'b0, 10);
    show(4'b1011, 6, 1'b0, 10);
    check_digits("rescan_digits", 16'h1624);
    check("rescan_valid", bus.frame_valid, 1'b1);
    check("rescan_strobes", strobe_cnt, 1);
    show_raw(4'b1111, 7'b1111111, 1'b1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required to accept a display state; legal range 2..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: cycles without a successful digit write before the frame is declared stale; legal range 16..2^24-1.
REQ-003 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port sevenSegmentsa2g, input, [0:6]: segments a..g (bit 0 = a); active-low.
REQ-006 Port anodeDrives, input, [3:0]: digit enables, bit 3 = leftmost digit; active-low.
REQ-007 Port dp, input, 1: decimal point; active-low.
REQ-008 Port digit3, digit2, digit1, digit0, output, 4 each: decoded hex value per digit position.
REQ-009 Port dp_mask, output, [3:0]: bit k = 1 when the decimal point was lit on digit k.
REQ-010 Port frame_valid, output, 1: all four digits refreshed since reset or the last timeout.
REQ-011 Port frame_strobe, output, 1: one-cycle pulse on each completed frame.
REQ-012 Port err_seg, output, 1: one-cycle pulse on an unrecognized segment pattern.
REQ-013 Port err_anode, output, 1: one-cycle pulse when more than one anode is active.

Function
REQ-014 Inputs {anodeDrives, sevenSegmentsa2g, dp} shall pass through a two-flop synchronizer before any other use.
REQ-015 Stability filter: a run counter shall clear whenever the synchronized vector differs from its previous-cycle value, and shall otherwise increment, saturating at STABLE_CYCLES.
REQ-016 The vector shall be "accepted" exactly once per stable run, on the cycle the run counter reaches STABLE_CYCLES-1; it is not accepted again until the vector changes.
REQ-017 Decode table, active-high abcdefg: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; all other patterns are invalid.
REQ-018 Accepted vector with zero active anodes: blanking; no state change, no error.
REQ-019 Accepted vector with more than one active anode: err_anode pulses on the next edge; digits, dp_mask, and seen are unchanged.
REQ-020 Accepted vector with exactly one active anode k and a valid pattern: on the next edge, digit k is written, dp_mask[k] is set to the inverted dp, and seen[k] is set.
REQ-021 Accepted vector with exactly one active anode and an invalid pattern: err_seg pulses; no write occurs and seen is unchanged.
REQ-022 Latency: for inputs stable from edge t, the digit write is visible after edge t+STABLE_CYCLES+2.
REQ-023 When a write makes seen == 4'b1111: frame_strobe pulses and frame_valid is set on the following edge, and seen clears to 0 on that same edge.
REQ-024 A write may update a digit whose seen bit is already set; the newest value wins and frame completion is unaffected.
REQ-025 Timeout counter: clears on every successful digit write, increments otherwise, and saturates at TIMEOUT_CYCLES.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES: frame_valid clears and seen clears; digit values and dp_mask are retained.
REQ-027 If a write and the timeout coincide on the same cycle, the write wins: the counter clears and frame_valid is unchanged by the timeout.
REQ-028 frame_strobe, err_seg, and err_anode shall be registered outputs and mutually independent; err_seg and err_anode never assert in the same cycle.

Reset
REQ-029 While reset = 0, all of the following shall hold asynchronously:
- digit0-3 = 0, dp_mask = 0
- frame_valid, frame_strobe, err_seg, err_anode = 0
- seen = 0, run counter = 0, timeout counter = 0
- synchronizer flops = all-ones (inactive display)
REQ-030 Reset release mid-scan shall require a full fresh stable run before any acceptance; no partial-run carry-over.

Verification
REQ-031 Scan anodes 1110, 1101, 1011, 0111 with patterns for 3, 0, 5, 1 and dp low on anode 1101, each held 10 cycles -> digit0=3, digit1=0, digit2=5, digit3=1, dp_mask=0010, one frame_strobe pulse, frame_valid=1.
REQ-032 Anode 1110 with a pattern toggling every 2 cycles for 20 cycles (STABLE_CYCLES=4) -> no write, no error pulses.
REQ-033 Anodes 1100 held 10 cycles -> exactly one err_anode pulse; digits unchanged.
REQ-034 Anode 1011 with pattern 1111111-inverted-except-g (0000001 active-high) -> one err_seg pulse; seen[2] remains 0.
REQ-035 TIMEOUT_CYCLES=16, complete one frame, then hold anodes at 1111 -> frame_valid drops 16 cycles after the last write; digits are retained.
REQ-036 Assert reset low mid-frame after three digits are written -> all outputs 0 immediately; a subsequent full scan yields exactly one frame_strobe.
